// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder: ALUOp classes, ALU operation
// codes and the canonical R-type funct values.
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // Only funct[3:0] distinguishes the R-type operations.
  function automatic logic is_base_funct(input logic [3:0] low);
    return (low == FUNCT_ADD[3:0]) || (low == FUNCT_SUB[3:0]) ||
           (low == FUNCT_AND[3:0]) || (low == FUNCT_OR[3:0])  ||
           (low == FUNCT_SLT[3:0]);
  endfunction

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational R-type funct decoder. Define ALU_CTRL_NOR_EN to add the
// NOR operation (funct[3:0]=0111) ahead of the normal priority rules.
module alu_funct_decode
  import alu_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] op,
  output logic       unsupported
);

  logic [3:0] low;
  assign low = funct[3:0];

  always_comb begin
    op          = OP_ADD;
    unsupported = !is_base_funct(low);
`ifdef ALU_CTRL_NOR_EN
    if (low == FUNCT_NOR[3:0]) begin
      op          = OP_NOR;
      unsupported = 1'b0;
    end else
`endif
    if (low[0])
      op = OP_OR;
    else if (low[1] && low[3])
      op = OP_SLT;
    else if (low[1])
      op = OP_SUB;
    else if (low[2])
      op = OP_AND;
    else
      op = OP_ADD;
  end

endmodule

// File: rtl/alu_control.sv
// Registered ALU control: selects add/sub/R-type decode on ALUOp and registers
// the operation code and unsupported flag. Optional macro: ALU_CTRL_NOR_EN.
module alu_control
  import alu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] ALUOp,
  input  logic [5:0] funct,
  output logic [3:0] operation,
  output logic       unsupported
);

  logic [3:0] rtype_op;
  logic       rtype_unsupported;
  logic [3:0] next_op;
  logic       next_unsupported;

  alu_funct_decode u_decode (
    .funct       (funct),
    .op          (rtype_op),
    .unsupported (rtype_unsupported)
  );

  // ALUOp 10 and 11 both select the R-type decode.
  always_comb begin
    next_op          = OP_ADD;
    next_unsupported = 1'b0;
    if (ALUOp[1]) begin
      next_op          = rtype_op;
      next_unsupported = rtype_unsupported;
    end else if (ALUOp == ALUOP_SUB) begin
      next_op = OP_SUB;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      operation   <= OP_AND;
      unsupported <= 1'b0;
    end else begin
      operation   <= next_op;
      unsupported <= next_unsupported;
    end
  end

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: directed plan plus random vectors
// against a behavioural model of the decode table.
module tb_alu_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] ALUOp;
  logic [5:0] funct;
  logic [3:0] operation;
  logic       unsupported;

  int checks = 0;
  int errors = 0;

  alu_control dut (
    .clk         (clk),
    .reset       (reset),
    .ALUOp       (ALUOp),
    .funct       (funct),
    .operation   (operation),
    .unsupported (unsupported)
  );

  always #5 clk = ~clk;

  // Reference: {unsupported, operation} from the plain decode rules.
  function automatic logic [4:0] refModel(input logic [1:0] op_class, input logic [5:0] f);
    int low;
    low = int'(f[3:0]);
    if (op_class == 2'd0) return {1'b0, 4'd2};
    if (op_class == 2'd1) return {1'b0, 4'd6};
`ifdef ALU_CTRL_NOR_EN
    if (low == 7) return {1'b0, 4'd12};
`endif
    begin
      logic [3:0] res;
      logic       bad;
      bad = !(low == 0 || low == 2 || low == 4 || low == 5 || low == 10);
      if (low % 2 == 1)                 res = 4'd1;
      else if ((low / 2) % 2 == 1)      res = (low >= 8) ? 4'd7 : 4'd6;
      else if ((low / 4) % 2 == 1)      res = 4'd0;
      else                              res = 4'd2;
      return {bad, res};
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Drive one vector, clock it in, then sample just after the edge.
  task automatic applyStimulus(input logic rst, input logic [1:0] op_class, input logic [5:0] f);
    reset = rst;
    ALUOp = op_class;
    funct = f;
    @(posedge clk);
    #1;
  endtask

  task automatic checkVector(input string tag, input logic [1:0] op_class, input logic [5:0] f);
    logic [4:0] exp;
    applyStimulus(1'b0, op_class, f);
    exp = refModel(op_class, f);
    checkOutput({tag, "_op"}, {4'b0, operation}, {4'b0, exp[3:0]});
    checkOutput({tag, "_unsup"}, {7'b0, unsupported}, {7'b0, exp[4]});
  endtask

  initial begin
    logic [5:0] canon [5];
    logic [3:0] canon_op [5];
    logic [1:0] r_op;
    logic [5:0] r_f;
    canon    = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    canon_op = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};

    reset = 1'b1;
    ALUOp = 2'b00;
    funct = 6'b0;
    @(negedge clk);

    applyStimulus(1'b1, 2'b10, 6'b100101);
    checkOutput("reset_op", {4'b0, operation}, 8'h00);
    checkOutput("reset_unsup", {7'b0, unsupported}, 8'h00);
    applyStimulus(1'b0, 2'b10, 6'b100101);
    checkOutput("release_op", {4'b0, operation}, 8'h01);
    checkOutput("release_unsup", {7'b0, unsupported}, 8'h00);

    for (int i = 0; i < 64; i++) checkVector("sweep00", 2'b00, 6'(i));
    for (int i = 0; i < 64; i++) checkVector("sweep01", 2'b01, 6'(i));

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 2'b10, canon[i]);
      checkOutput("canon_op", {4'b0, operation}, {4'b0, canon_op[i]});
      checkOutput("canon_unsup", {7'b0, unsupported}, 8'h00);
    end

    applyStimulus(1'b0, 2'b10, 6'b000011);
    checkOutput("nc03_op", {4'b0, operation}, 8'h01);
    checkOutput("nc03_unsup", {7'b0, unsupported}, 8'h01);
    applyStimulus(1'b0, 2'b10, 6'b001110);
    checkOutput("nc0e_op", {4'b0, operation}, 8'h07);
    checkOutput("nc0e_unsup", {7'b0, unsupported}, 8'h01);
    applyStimulus(1'b0, 2'b10, 6'b111000);
    checkOutput("nc38_op", {4'b0, operation}, 8'h02);
    checkOutput("nc38_unsup", {7'b0, unsupported}, 8'h01);
    applyStimulus(1'b0, 2'b11, 6'b100010);
    checkOutput("aluop11_op", {4'b0, operation}, 8'h06);
    checkOutput("aluop11_unsup", {7'b0, unsupported}, 8'h00);

    applyStimulus(1'b0, 2'b10, 6'b100111);
`ifdef ALU_CTRL_NOR_EN
    checkOutput("nor_op", {4'b0, operation}, 8'h0c);
    checkOutput("nor_unsup", {7'b0, unsupported}, 8'h00);
`else
    checkOutput("nor_op", {4'b0, operation}, 8'h01);
    checkOutput("nor_unsup", {7'b0, unsupported}, 8'h01);
`endif

    // Mid-cycle input change must not disturb the registered outputs.
    applyStimulus(1'b0, 2'b10, 6'b101010);
    ALUOp = 2'b00;
    funct = 6'b000000;
    #3;
    checkOutput("midcycle_op", {4'b0, operation}, 8'h07);

    for (int i = 0; i < 300; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_f  = 6'($urandom);
      checkVector("random", r_op, r_f);
    end

    // Reset again mid-stream with a non-zero decode pending.
    applyStimulus(1'b1, 2'b01, 6'b0);
    checkOutput("reset2_op", {4'b0, operation}, 8'h00);
    checkVector("after_reset2", 2'b01, 6'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_control.md
Name: alu_control

Overview:
- Registered ALU control decoder for the single-cycle/multicycle MIPS-style datapath.
- Maps the 2-bit ALUOp from the main control and the 6-bit instruction funct field to the 4-bit ALU operation code.
- Sits between the main control unit / instruction register and the ALU operation input.
- Decode logic is combinational; the outputs are registered on the single clock.

Parameters:
- None. All widths are fixed: ALUOp 2 bits, funct 6 bits, operation 4 bits.

Ports:
- clk  input  1  system clock; rising-edge active.
- reset  input  1  synchronous, active-high reset.
- ALUOp  input  2  operation class from main control.
- funct  input  6  instruction funct field, bits [5:0].
- operation  output  4  ALU operation code, registered.
- unsupported  output  1  registered flag; high when an R-type funct is not a defined code.

Behaviour:
- Reset: on a rising clk edge with reset=1, operation <= 4'b0000 and unsupported <= 0. Reset has priority over decode.
- Latency: outputs reflect the ALUOp/funct values sampled at a rising clk edge, one cycle later. There is no enable; the registers update every cycle.
- ALUOp=00 (load/store address): operation=0010 (add). funct is ignored. unsupported=0.
- ALUOp=01 (branch compare): operation=0110 (sub). funct is ignored. unsupported=0.
- ALUOp=1x (R-type; 10 and 11 decode identically): funct[5:4] is ignored. Priority decode:
  - funct[0]=1 -> 0001 (OR).
  - else funct[1]=1 and funct[3]=1 -> 0111 (SLT).
  - else funct[1]=1 and funct[3]=0 -> 0110 (SUB).
  - else funct[2]=1 -> 0000 (AND).
  - else -> 0010 (ADD).
- Canonical R-type codes:
  - 100000 -> 0010
  - 100010 -> 0110
  - 100100 -> 0000
  - 100101 -> 0001
  - 101010 -> 0111
- Every funct value produces a deterministic result through the priority rules above. Non-canonical values also decode this way; X/Z must never be driven.
- unsupported=1 iff ALUOp[1]=1 and funct[3:0] is not in {0000, 0010, 0100, 0101, 1010}. This set is extended by the optional feature below.
- Inputs that change mid-cycle have no effect until the next edge.
- Deasserting reset: the first decode appears one edge after the first non-reset edge samples the inputs.

Optional Feature:
- Macro: ALU_CTRL_NOR_EN.
- Defined: with ALUOp=1x and funct[3:0]=0111, operation=1100 (NOR) and unsupported=0. This case is checked before the funct[0] rule.
- Undefined: funct[3:0]=0111 decodes by the normal priority rules to 0001 (OR) and unsupported=1.
- All other behaviour is identical in both builds.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALUOp encodings: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_RTYPE=10.
  - Operation codes: OP_AND=0000, OP_OR=0001, OP_ADD=0010, OP_SUB=0110, OP_SLT=0111, OP_NOR=1100.
  - Canonical funct constants.
- One combinational sub-module, alu_funct_decode: inputs funct[5:0]; outputs the R-type op[3:0] and an unsupported bit.
- The top level selects on ALUOp and registers both outputs.

Test Plan:
- Reset: assert reset with ALUOp=10, funct=100101 -> after the edge, operation=0000 and unsupported=0. Release reset -> next edge gives operation=0001.
- ALUOp=00, sweep funct 0..63 -> operation=0010 and unsupported=0 every cycle, with 1-cycle latency.
- ALUOp=01, sweep funct 0..63 -> operation=0110 and unsupported=0 for all values.
- ALUOp=10, canonical codes -> required results:
  - 100000 -> 0010
  - 100010 -> 0110
  - 100100 -> 0000
  - 100101 -> 0001
  - 101010 -> 0111
  - unsupported=0 for all of these.
- ALUOp=10, non-canonical codes -> required results:
  - 000011 -> 0001, unsupported=1.
  - 001110 -> 0111, unsupported=1.
  - 111000 -> 0010, unsupported=1.
  - ALUOp=11 with 100010 -> 0110.
- Macro check: ALUOp=10, funct=100111 -> with ALU_CTRL_NOR_EN, 1100 and unsupported=0. Without it, 0001 and unsupported=1.
